seg_scan_controller: RTL
========================

# seg_scan_controller

Time-multiplexed scan controller for the four-digit seven-segment display. It sits upstream of the segment decoder/driver: it owns the active-low anode strobes and presents the hex nibble to be decoded for the currently strobed digit. A digit-to-digit dead time prevents ghosting. A shadow register ensures a new 16-bit display value only takes effect at a frame boundary. The block also provides optional leading-zero blanking.

## Interface
- DIV, 50000: clock cycles per digit slot; legal range DIV ≥ 2.
- DEAD, 4: cycles at the start of each slot with all anodes off; legal range 0 ≤ DEAD < DIV.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- value_in  input  16  display value; [15:12] is digit 0 (leftmost), [3:0] is digit 3.
- value_load  input  1  single-cycle strobe; captures value_in.
- blank_lz  input  1  1 enables leading-zero blanking; sampled every cycle.
- an  output  4  anode strobes, active low; an[d] selects digit d.
- char  output  4  nibble for the current digit, fed to the segment decoder.
- pending  output  1  1 while a loaded value waits for the next frame boundary.
- frame_tick  output  1  one-cycle pulse in the first cycle of each frame.

## Operation
- Internal state:
  - slot counter cnt, 0..DIV-1, width $clog2(DIV);
  - digit index d, 0..3;
  - display register disp[15:0];
  - shadow register shd[15:0];
  - pending flag.
- Scan sequence: d advances 0→1→2→3→0. cnt wraps DIV-1→0 on every slot change. One frame is 4·DIV cycles.
- Within a slot, phases are decided by cnt:
  - DEAD phase (cnt < DEAD): an = 4'b1111.
  - ON phase (cnt ≥ DEAD): an[d] = 0, all other bits 1, unless digit d is blanked.
- char = disp nibble of digit d for the whole slot, including the DEAD phase and blanked slots.
- Leading-zero blanking: with blank_lz = 1, digit d (d < 3) is blanked when every nibble of digits 0..d in disp is zero. A blanked digit keeps its anode high for the entire slot. Digit 3 is never blanked, so 0x0000 displays a single "0".
- Load handling:
  - value_load = 1 writes shd ← value_in and sets pending = 1.
  - Repeated loads before a boundary overwrite shd; the last load wins.
- Frame boundary is the edge where cnt = DIV-1 and d = 3. On that edge:
  - if value_load = 1, disp ← value_in, and pending ← 0;
  - else if pending = 1, disp ← shd, and pending ← 0;
  - otherwise disp is unchanged.
- frame_tick = 1 exactly in the cycle where cnt = 0 and d = 0. It is not asserted in the first cycle after reset release.

## Timing
- Reset values, applied immediately and asynchronously on reset:
  - an = 4'b1111, char = 4'h0, pending = 0, frame_tick = 0;
  - cnt = 0, d = 0, disp = 16'h0000, shd = 16'h0000.
- All outputs are registered. an and char update on the same edge as cnt and d, so they always reflect the current (cnt, d).
- After reset deasserts, the first rising edge is cycle 0 (cnt = 0, d = 0). Output an[0] first goes low at cycle DEAD, with disp = 0 and blank_lz = 0.
- value_load to pending is one cycle: pending reads 1 in the cycle after the strobe edge.
- Load to visible output: the new value appears at the next frame_tick cycle. Worst-case latency is 4·DIV cycles.
- blank_lz and disp changes take effect on the next edge; a change mid-slot may alter an within that slot.
- Reset asserted mid-slot or mid-frame: every output goes to its reset value without a clock. A pending load is discarded.
- DEAD = 0: the anode is low for all DIV cycles of the slot; there is no all-off cycle.

## Test plan
Common setup for all scenarios: DIV = 8, DEAD = 2.
- Reset: hold reset for 3 cycles, then release → during reset an = 1111, char = 0, pending = 0, frame_tick = 0. After release an[0] goes low at cycle 2 and an = 1101 at cycle 10.
- Mid-frame load: pulse value_load with 16'h12AB at cnt = 3, d = 1 →
  - pending = 1 the next cycle;
  - char stays 0 until the boundary;
  - after frame_tick, char sequence is 1, 2, A, B, and an is 1110, 1101, 1011, 0111;
  - each anode is low 6 cycles, with 2 all-off cycles between digits;
  - pending = 0 in the frame_tick cycle.
- Leading-zero blanking with blank_lz = 1:
  - disp = 0x0005 → an[2:0] stay high all frame, an[3] is low 6 cycles with char = 5;
  - disp = 0x0000 → only an[3] strobes;
  - disp = 0x0005 with blank_lz = 0 → all four anodes strobe, showing 0, 0, 0, 5.
- Multiple and coincident loads:
  - load 0x1111 then 0x2222 within one frame → the next frame shows 2222;
  - a load of 0x3333 on the boundary edge → the frame starting at frame_tick shows 3333, with pending = 0.
- Reset mid-operation: assert reset at cnt = 5, d = 2 while pending = 1 → an = 1111 and pending = 0 immediately. After release disp = 0 and scanning restarts at d = 0, cnt = 0.
- frame_tick period: run 3 frames with no loads → frame_tick pulses exactly once every 32 cycles and is 1 cycle wide.

Source files
------------

// File: rtl/seg_scan_controller.sv
// Four-digit seven-segment scan controller: anode strobing with dead time,
// frame-aligned shadow loading and optional leading-zero blanking.
module seg_scan_controller #(
    parameter int DIV  = 50000,
    parameter int DEAD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        value_load,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [3:0]  char,
    output logic        pending,
    output logic        frame_tick
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    d, d_n;
    logic [15:0]   disp, disp_n, shd, shd_n;
    logic          run;
    logic          pend_n, boundary, blank, z0, z1, z2;
    logic [3:0]    an_n, char_n;
    logic          ft_n;

    always_comb begin
        cnt_n    = cnt;
        d_n      = d;
        boundary = 1'b0;
        // the first edge after reset only establishes cycle 0; counting starts after it
        if (run) begin
            if (cnt == LAST) begin
                cnt_n    = '0;
                d_n      = d + 2'd1;
                boundary = (d == 2'd3);
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end

        disp_n = disp;
        if (boundary) begin
            if (value_load)
                disp_n = value_in;
            else if (pending)
                disp_n = shd;
        end
        shd_n  = value_load ? value_in : shd;
        pend_n = boundary ? 1'b0 : (pending | value_load);

        z0 = (disp_n[15:12] == 4'h0);
        z1 = z0 && (disp_n[11:8] == 4'h0);
        z2 = z1 && (disp_n[7:4] == 4'h0);
        case (d_n)
            2'd0:    blank = blank_lz & z0;
            2'd1:    blank = blank_lz & z1;
            2'd2:    blank = blank_lz & z2;
            default: blank = 1'b0;
        endcase

        char_n = disp_n[4*(3 - d_n) +: 4];
        an_n   = (int'(cnt_n) < DEAD || blank) ? 4'hF : ~(4'b0001 << d_n);
        ft_n   = run && (cnt_n == '0) && (d_n == 2'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            d          <= 2'd0;
            disp       <= 16'h0000;
            shd        <= 16'h0000;
            pending    <= 1'b0;
            run        <= 1'b0;
            an         <= 4'hF;
            char       <= 4'h0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            d          <= d_n;
            disp       <= disp_n;
            shd        <= shd_n;
            pending    <= pend_n;
            run        <= 1'b1;
            an         <= an_n;
            char       <= char_n;
            frame_tick <= ft_n;
        end
    end
endmodule
